branch_predictor: RTL and testbench

Front-end next-PC predictor, instantiated inside the Decoder. Each cycle it takes the instruction presented by the Fetcher, its address and the Decoder-computed immediate, and produces `new_pc` combinationally. The Fetcher uses `new_pc` as `predict_pc` for the next fetch. Conditional branches are predicted by a table of 2-bit saturating counters, trained by branch-resolution feedback from the RoB.

---
 rtl/branch_predictor_pkg.sv | 35 +++
 rtl/bht_table.sv | 46 ++++
 rtl/branch_predictor.sv | 68 ++++++
 tb/tb_branch_predictor.sv | 183 ++++++++++++++++++
 4 files changed

// File: rtl/branch_predictor_pkg.sv
// Shared configuration for the front-end next-PC predictor: opcode constants,
// default counter-table size and the 2-bit saturating counter step.
`default_nettype none

package branch_predictor_pkg;

    localparam int BHT_INDEX_W = 6;

    localparam logic [6:0] LUI     = 7'b0110111;
    localparam logic [6:0] AUIPC   = 7'b0010111;
    localparam logic [6:0] JAL     = 7'b1101111;
    localparam logic [6:0] JALR    = 7'b1100111;
    localparam logic [6:0] B_TYPE  = 7'b1100011;
    localparam logic [6:0] LD_TYPE = 7'b0000011;
    localparam logic [6:0] S_TYPE  = 7'b0100011;
    localparam logic [6:0] I_TYPE  = 7'b0010011;
    localparam logic [6:0] R_TYPE  = 7'b0110011;

    // Weak not-taken: one taken outcome is enough to flip the prediction.
    localparam logic [1:0] CTR_RESET = 2'b01;

    function automatic logic [1:0] sat_update(input logic [1:0] ctr, input logic taken);
        logic [1:0] res;
        res = ctr;
        if (taken) begin
            if (ctr != 2'b11) res = ctr + 2'd1;
        end else begin
            if (ctr != 2'b00) res = ctr - 2'd1;
        end
        return res;
    endfunction

endpackage

`default_nettype wire

// File: rtl/bht_table.sv
// Table of 2-bit saturating counters: one async read port, one synchronous
// saturating-update port, async active-low reset to weak not-taken.
`default_nettype none

module bht_table
    import branch_predictor_pkg::*;
#(
    parameter int IDX_W = 6
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [IDX_W-1:0] rd_idx_i,
    output logic [1:0]       rd_ctr_o,
    input  logic             upd_en_i,
    input  logic [IDX_W-1:0] upd_idx_i,
    input  logic             upd_taken_i
);

    localparam int ENTRIES = 2 ** IDX_W;

    logic [1:0] ctr_q [ENTRIES];
    logic [1:0] ctr_d [ENTRIES];

    // Read returns the pre-update value when read and update hit the same entry.
    assign rd_ctr_o = ctr_q[rd_idx_i];

    always_comb begin
        ctr_d = ctr_q;
        if (upd_en_i) begin
            ctr_d[upd_idx_i] = sat_update(ctr_q[upd_idx_i], upd_taken_i);
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            for (int i = 0; i < ENTRIES; i++) begin
                ctr_q[i] <= CTR_RESET;
            end
        end else begin
            ctr_q <= ctr_d;
        end
    end

endmodule

`default_nettype wire

// File: rtl/branch_predictor.sv
// Combinational next-PC predictor. Define PREDICTOR_BHT_EN for the trained
// 2-bit counter table; otherwise B-types use static backward-taken.
`default_nettype none

module branch_predictor
    import branch_predictor_pkg::*;
#(
    parameter int BHT_INDEX_W = branch_predictor_pkg::BHT_INDEX_W
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        rdy,
    input  logic [31:0] pc,
    input  logic [31:0] instr,
    input  logic [31:0] imm,
    output logic [31:0] new_pc,
    output logic        pred_taken,
    input  logic        upd_valid,
    input  logic [31:0] upd_pc,
    input  logic        upd_taken
);

    logic [6:0]  w_opcode;
    logic [31:0] w_target;
    logic [31:0] w_seq_pc;
    logic        w_br_taken;
    logic        unused_bits;

    assign w_opcode = instr[6:0];
    assign w_target = pc + imm;
    assign w_seq_pc = pc + 32'd4;

`ifdef PREDICTOR_BHT_EN
    logic [1:0] w_ctr;

    bht_table #(
        .IDX_W (BHT_INDEX_W)
    ) u_bht_table (
        .clk         (clk),
        .rst         (rst),
        .rd_idx_i    (pc[BHT_INDEX_W+1:2]),
        .rd_ctr_o    (w_ctr),
        .upd_en_i    (rdy & upd_valid),
        .upd_idx_i   (upd_pc[BHT_INDEX_W+1:2]),
        .upd_taken_i (upd_taken)
    );

    assign w_br_taken  = w_ctr[1];
    assign unused_bits = ^{upd_pc[31:BHT_INDEX_W+2], upd_pc[1:0], instr[31:7]};
`else
    // Backward branches (negative offset) are usually loop back-edges.
    assign w_br_taken  = imm[31];
    assign unused_bits = ^{clk, rst, rdy, upd_valid, upd_pc, upd_taken, instr[31:7]};
`endif

    always_comb begin
        pred_taken = 1'b0;
        case (w_opcode)
            JAL:     pred_taken = 1'b1;
            B_TYPE:  pred_taken = w_br_taken;
            default: pred_taken = 1'b0;
        endcase
        new_pc = pred_taken ? w_target : w_seq_pc;
    end

endmodule

`default_nettype wire

// File: tb/tb_branch_predictor.sv
// Directed self-checking bench for branch_predictor (both table and static builds).
`default_nettype none
`timescale 1ns/1ps

module tb_branch_predictor;

    localparam logic [31:0] INSTR_B    = 32'h0000_0063;
    localparam logic [31:0] INSTR_JAL  = 32'h0000_006F;
    localparam logic [31:0] INSTR_JALR = 32'h0000_0067;
    localparam logic [31:0] INSTR_LUI  = 32'h0000_0037;

    logic        clk;
    logic        rst;
    logic        rdy;
    logic [31:0] pc;
    logic [31:0] instr;
    logic [31:0] imm;
    logic [31:0] new_pc;
    logic        pred_taken;
    logic        upd_valid;
    logic [31:0] upd_pc;
    logic        upd_taken;

    int n_checks = 0;
    int n_fail   = 0;

    branch_predictor dut (
        .clk        (clk),
        .rst        (rst),
        .rdy        (rdy),
        .pc         (pc),
        .instr      (instr),
        .imm        (imm),
        .new_pc     (new_pc),
        .pred_taken (pred_taken),
        .upd_valid  (upd_valid),
        .upd_pc     (upd_pc),
        .upd_taken  (upd_taken)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", tag, obs, exp);
        end
    endtask

    task automatic present(input logic [31:0] p, input logic [31:0] ins, input logic [31:0] im);
        pc    = p;
        instr = ins;
        imm   = im;
        #1;
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic do_update(input logic [31:0] p, input logic t, input int n);
        for (int k = 0; k < n; k++) begin
            upd_valid = 1'b1;
            upd_pc    = p;
            upd_taken = t;
            tick();
        end
        upd_valid = 1'b0;
        #1;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        rst = 1'b0; rdy = 1'b1;
        pc = '0; instr = '0; imm = '0;
        upd_valid = 1'b0; upd_pc = '0; upd_taken = 1'b0;

        // Outputs follow combinational rules while reset is held.
        present(32'h100, INSTR_B, 32'h20);
        check_eq("reset_b_pc", new_pc, 32'h104);
        check_eq("reset_b_tk", {31'd0, pred_taken}, 32'd0);
        tick(); tick();
        rst = 1'b1;
        tick();

        present(32'h100, INSTR_B, 32'h20);
        check_eq("b_init_pc", new_pc, 32'h104);
        check_eq("b_init_tk", {31'd0, pred_taken}, 32'd0);

        present(32'h200, INSTR_JAL, 32'hFFFF_FFF0);
        check_eq("jal_pc", new_pc, 32'h1F0);
        check_eq("jal_tk", {31'd0, pred_taken}, 32'd1);
        present(32'h200, INSTR_JALR, 32'hFFFF_FFF0);
        check_eq("jalr_pc", new_pc, 32'h204);
        check_eq("jalr_tk", {31'd0, pred_taken}, 32'd0);
        present(32'h300, INSTR_LUI, 32'h1234_5000);
        check_eq("lui_pc", new_pc, 32'h304);
        present(32'hFFFF_FFFC, INSTR_JAL, 32'h8);
        check_eq("jal_wrap", new_pc, 32'h0000_0004);
        present(32'hFFFF_FFFC, INSTR_B, 32'h8);
        check_eq("b_seq_wrap", new_pc, 32'h0000_0000);

`ifdef PREDICTOR_BHT_EN
        // 01 -> 10 -> 11: taken.
        do_update(32'h100, 1'b1, 2);
        present(32'h100, INSTR_B, 32'h20);
        check_eq("train_tk_pc", new_pc, 32'h120);
        check_eq("train_tk_tk", {31'd0, pred_taken}, 32'd1);
        // Aliased index (0x100 + 256) sees the same counter.
        present(32'h200, INSTR_B, 32'h40);
        check_eq("alias_pc", new_pc, 32'h240);
        // 11 -> 10: still taken.
        do_update(32'h100, 1'b0, 1);
        present(32'h100, INSTR_B, 32'h20);
        check_eq("weak_tk_pc", new_pc, 32'h120);
        // 10 -> 01 -> 00.
        do_update(32'h100, 1'b0, 2);
        check_eq("train_nt_pc", new_pc, 32'h104);
        check_eq("train_nt_tk", {31'd0, pred_taken}, 32'd0);
        // Saturate at 00, then one taken -> 01: still not-taken.
        do_update(32'h100, 1'b0, 2);
        do_update(32'h100, 1'b1, 1);
        check_eq("sat_low_pc", new_pc, 32'h104);
        // Same-cycle lookup and update from 01 with taken.
        upd_valid = 1'b1; upd_pc = 32'h100; upd_taken = 1'b1;
        #1;
        check_eq("same_cyc_pre", new_pc, 32'h104);
        tick();
        upd_valid = 1'b0;
        #1;
        check_eq("same_cyc_post", new_pc, 32'h120);
        // Another entry untouched.
        present(32'h104, INSTR_B, 32'h20);
        check_eq("other_idx_pc", new_pc, 32'h108);
        present(32'h100, INSTR_B, 32'h20);
        // rdy low freezes the table.
        rdy = 1'b0;
        do_update(32'h100, 1'b0, 3);
        check_eq("rdy_frozen_pc", new_pc, 32'h120);
        rdy = 1'b1;
        #1;
        // Async reset discards training without a clock edge.
        @(negedge clk);
        #1;
        rst = 1'b0;
        #1;
        check_eq("async_rst_pc", new_pc, 32'h104);
        check_eq("async_rst_tk", {31'd0, pred_taken}, 32'd0);
        #1;
        rst = 1'b1;
        tick();
        check_eq("post_rst_pc", new_pc, 32'h104);
`else
        // Static backward-taken / forward-not-taken.
        present(32'h100, INSTR_B, 32'hFFFF_FFF8);
        check_eq("static_bwd_pc", new_pc, 32'hF8);
        check_eq("static_bwd_tk", {31'd0, pred_taken}, 32'd1);
        present(32'h100, INSTR_B, 32'h8);
        check_eq("static_fwd_pc", new_pc, 32'h104);
        check_eq("static_fwd_tk", {31'd0, pred_taken}, 32'd0);
        // Update ports have no effect.
        present(32'h100, INSTR_B, 32'h20);
        do_update(32'h100, 1'b1, 3);
        check_eq("static_upd_ign", new_pc, 32'h104);
        present(32'h0, INSTR_B, 32'h8000_0000);
        check_eq("static_min_imm", new_pc, 32'h8000_0000);
`endif

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

`default_nettype wire
